// File: rtl/i2s_master_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_master_tx
// Brief    : I2S clock-master transmitter. Generates BCLK/LRCK from iCLK and
//            serialises stereo samples taken through a one-deep holding
//            register. Define I2S_LEFT_JUSTIFIED_EN for left-justified format.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_master_tx #(
  parameter int WS        = 16,
  parameter int SLOT_BITS = 32,
  parameter int BCLK_DIV  = 8
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic [WS-1:0] iL,
  input  logic [WS-1:0] iR,
  input  logic          iValid,
  output logic          oReady,
  output logic          oBCLK,
  output logic          oLRCK,
  output logic          oDAT,
  output logic          oSampleTick,
  output logic          oUnderrun
);

  localparam int c_FRAME_BITS = 2 * SLOT_BITS;
  localparam int c_BW         = $clog2(c_FRAME_BITS);
  localparam int c_PW         = $clog2(SLOT_BITS);
  localparam int c_DW         = $clog2(BCLK_DIV);
`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam int   c_SHIFT      = SLOT_BITS - WS;
  localparam logic c_LRCK_RIGHT = 1'b0;
`else
  localparam int   c_SHIFT      = SLOT_BITS - WS - 1;
  localparam logic c_LRCK_RIGHT = 1'b1;
`endif

  logic [c_DW-1:0]      r_div;
  logic                 r_bclk;
  logic                 r_lrck;
  logic                 r_dat;
  logic                 r_full;
  logic                 r_tick;
  logic                 r_und;
  logic [c_BW-1:0]      r_bcnt;
  logic [WS-1:0]        r_hold_l;
  logic [WS-1:0]        r_hold_r;
  logic [2*WS-1:0]      r_frame;

  logic                 w_tc;
  logic                 w_fall;
  logic                 w_load;
  logic                 w_accept;
  logic                 w_right;
  logic [c_BW-1:0]      w_bnext;
  logic [c_BW-1:0]      w_pos;
  logic [c_PW-1:0]      w_idx;
  logic [2*WS-1:0]      w_frame_nxt;
  logic [WS-1:0]        w_word;
  logic [SLOT_BITS-1:0] w_slot;

  assign w_tc     = (r_div == c_DW'(BCLK_DIV - 1));
  assign w_fall   = w_tc & r_bclk;
  assign w_accept = iValid & ~r_full;

  assign w_bnext = (r_bcnt == c_BW'(c_FRAME_BITS - 1)) ? '0 : r_bcnt + c_BW'(1);
  assign w_load  = w_fall & (w_bnext == '0);
  assign w_right = (w_bnext >= c_BW'(SLOT_BITS));
  assign w_pos   = w_right ? (w_bnext - c_BW'(SLOT_BITS)) : w_bnext;
  assign w_idx   = c_PW'(c_BW'(SLOT_BITS - 1) - w_pos);

  // The load cycle also emits slot bit 0, so it must see the incoming frame.
  assign w_frame_nxt = w_load ? (r_full ? {r_hold_l, r_hold_r} : '0) : r_frame;
  assign w_word      = w_right ? w_frame_nxt[WS-1:0] : w_frame_nxt[2*WS-1:WS];
  // Slot laid out MSB-first: bit SLOT_BITS-1 is transmitted at slot position 0.
  assign w_slot      = SLOT_BITS'(w_word) << c_SHIFT;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_div    <= '0;
      r_bclk   <= 1'b0;
      r_lrck   <= c_LRCK_RIGHT;
      r_dat    <= 1'b0;
      r_bcnt   <= c_BW'(c_FRAME_BITS - 1);
      r_full   <= 1'b0;
      r_tick   <= 1'b0;
      r_und    <= 1'b0;
      r_hold_l <= '0;
      r_hold_r <= '0;
      r_frame  <= '0;
    end else begin
      r_div  <= w_tc ? '0 : r_div + c_DW'(1);
      r_tick <= w_load;
      r_und  <= w_load & ~r_full;
      if (w_tc) begin
        r_bclk <= ~r_bclk;
      end
      if (w_fall) begin
        r_bcnt  <= w_bnext;
        r_lrck  <= w_right ? c_LRCK_RIGHT : ~c_LRCK_RIGHT;
        r_dat   <= w_slot[w_idx];
        r_frame <= w_frame_nxt;
      end
      // Load consults the pre-edge holding state; a same-cycle accept lands
      // only when the holding was empty, so it survives into the next frame.
      if (w_load && r_full) begin
        r_full <= 1'b0;
      end else if (w_accept) begin
        r_full   <= 1'b1;
        r_hold_l <= iL;
        r_hold_r <= iR;
      end
    end
  end

  assign oReady      = ~r_full;
  assign oBCLK       = r_bclk;
  assign oLRCK       = r_lrck;
  assign oDAT        = r_dat;
  assign oSampleTick = r_tick;
  assign oUnderrun   = r_und;

endmodule
`default_nettype wire
